// File: rtl/dbg_pkg.sv
// Shared definitions for the UART debug command sequencer: command and
// reply byte codes, FSM state encoding and a byte-select helper.
package dbg_pkg;

    localparam int DATA_W = 8;

    // Command bytes accepted from the host
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'

    // Reply bytes sent back to the host
    localparam logic [7:0] ACK_BYTE = 8'h4B;  // 'K'
    localparam logic [7:0] ERR_BYTE = 8'h3F;  // '?'

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LD_CNT   = 4'd1,
        ST_LD_BYTE  = 4'd2,
        ST_LD_WRITE = 4'd3,
        ST_RUN      = 4'd4,
        ST_STEP     = 4'd5,
        ST_DUMP_RD  = 4'd6,
        ST_DUMP_TX  = 4'd7,
        ST_SEND     = 4'd8
    } dbg_state_t;

    // Select byte idx of a 32-bit word, byte 0 being bits [7:0]
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dbg_word_tx.sv
// Serializes a 32-bit word into four bytes, LSB first, onto the TX FIFO
// push interface while honouring tx_full back-pressure. The word is
// captured while byte 0 is pending, so the source only has to be valid
// until the first byte has been accepted.
module dbg_word_tx
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] word,
    input  logic        tx_full,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        done
);

    logic [1:0]  cnt_reg;
    logic [31:0] word_reg;
    logic [31:0] cur_word;

    // Byte 0 comes straight from the source; later bytes from the capture
    always_comb begin
        cur_word = (cnt_reg == 2'd0) ? word : word_reg;
        tx_wr    = en && !tx_full;
        tx_data  = word_byte(cur_word, cnt_reg);
        done     = tx_wr && (cnt_reg == 2'd3);
    end

    // Byte index advances only on an accepted push; wraps to 0 after byte 3
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg  <= 2'd0;
            word_reg <= 32'd0;
        end else begin
            if (en && cnt_reg == 2'd0)
                word_reg <= word;
            if (tx_wr)
                cnt_reg <= cnt_reg + 2'd1;
        end
    end

endmodule

// File: rtl/uart_debug_ctrl.sv
// Command sequencer between the UART RX/TX byte FIFOs and the core:
// program load into instruction memory, run-to-halt, single step and
// register dump. Owns the core clock-enable exclusively.
module uart_debug_ctrl
    import dbg_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IMEM_AW    = 8,
    parameter int DBG_AW     = 5,
    parameter int DUMP_WORDS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               rx_empty,
    output logic               rx_rd,
    input  logic               tx_full,
    output logic               tx_wr,
    output logic [DATA_W-1:0]  tx_data,
    output logic               cpu_en,
    input  logic               cpu_halted,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic [DBG_AW-1:0]  dbg_addr,
    input  logic [31:0]        dbg_rdata
);

    localparam logic [DBG_AW-1:0] LAST_IDX = DBG_AW'(DUMP_WORDS - 1);

    dbg_state_t         state_reg, state_next;
    logic [1:0]         byte_cnt_reg, byte_cnt_next;
    logic [7:0]         word_cnt_reg, word_cnt_next;
    logic [IMEM_AW-1:0] ptr_reg, ptr_next;
    logic [31:0]        word_reg, word_next;
    logic [DBG_AW-1:0]  dump_idx_reg, dump_idx_next;
    logic [7:0]         send_byte_reg, send_byte_next;

    logic               rx_pop;
    logic               ser_en;
    logic               ser_wr;
    logic [7:0]         ser_data;
    logic               ser_done;

    dbg_word_tx u_word_tx (
        .clk     (clk),
        .reset   (reset),
        .en      (ser_en),
        .word    (dbg_rdata),
        .tx_full (tx_full),
        .tx_wr   (ser_wr),
        .tx_data (ser_data),
        .done    (ser_done)
    );

    // State and datapath registers; reset discards any partial load word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            byte_cnt_reg  <= 2'd0;
            word_cnt_reg  <= 8'd0;
            ptr_reg       <= '0;
            word_reg      <= 32'd0;
            dump_idx_reg  <= '0;
            send_byte_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            word_cnt_reg  <= word_cnt_next;
            ptr_reg       <= ptr_next;
            word_reg      <= word_next;
            dump_idx_reg  <= dump_idx_next;
            send_byte_reg <= send_byte_next;
        end
    end

    // Next-state and handshake outputs; every strobe is a same-cycle
    // function of the FIFO flags so nothing fires against a stale flag
    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        word_cnt_next  = word_cnt_reg;
        ptr_next       = ptr_reg;
        word_next      = word_reg;
        dump_idx_next  = dump_idx_reg;
        send_byte_next = send_byte_reg;
        rx_pop         = 1'b0;
        tx_wr          = 1'b0;
        tx_data        = '0;
        cpu_en         = 1'b0;
        imem_we        = 1'b0;
        ser_en         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    case (rx_data[7:0])
                        CMD_LOAD: state_next = ST_LD_CNT;
                        CMD_RUN:  state_next = ST_RUN;
                        CMD_STEP: state_next = ST_STEP;
                        CMD_DUMP: begin
                            dump_idx_next = '0;
                            state_next    = ST_DUMP_RD;
                        end
                        default: begin
                            send_byte_next = ERR_BYTE;
                            state_next     = ST_SEND;
                        end
                    endcase
                end
            end

            ST_LD_CNT: begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    if (rx_data[7:0] == 8'd0) begin
                        send_byte_next = ACK_BYTE;
                        state_next     = ST_SEND;
                    end else begin
                        word_cnt_next = rx_data[7:0];
                        ptr_next      = '0;
                        byte_cnt_next = 2'd0;
                        state_next    = ST_LD_BYTE;
                    end
                end
            end

            ST_LD_BYTE: begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    word_next[{byte_cnt_reg, 3'b000} +: 8] = rx_data[7:0];
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3)
                        state_next = ST_LD_WRITE;
                end
            end

            ST_LD_WRITE: begin
                imem_we       = 1'b1;
                ptr_next      = ptr_reg + 1'b1;
                word_cnt_next = word_cnt_reg - 8'd1;
                if (word_cnt_reg == 8'd1) begin
                    send_byte_next = ACK_BYTE;
                    state_next     = ST_SEND;
                end else begin
                    state_next = ST_LD_BYTE;
                end
            end

            ST_RUN: begin
                if (cpu_halted) begin
                    send_byte_next = ACK_BYTE;
                    state_next     = ST_SEND;
                end else begin
                    cpu_en = 1'b1;
                end
            end

            ST_STEP: begin
                cpu_en         = 1'b1;
                send_byte_next = ACK_BYTE;
                state_next     = ST_SEND;
            end

            ST_DUMP_RD: begin
                state_next = ST_DUMP_TX;
            end

            ST_DUMP_TX: begin
                ser_en  = 1'b1;
                tx_wr   = ser_wr;
                tx_data = DATA_W'(ser_data);
                if (ser_done) begin
                    if (dump_idx_reg == LAST_IDX) begin
                        dump_idx_next = '0;
                        state_next    = ST_IDLE;
                    end else begin
                        dump_idx_next = dump_idx_reg + 1'b1;
                        state_next    = ST_DUMP_RD;
                    end
                end
            end

            ST_SEND: begin
                tx_data = DATA_W'(send_byte_reg);
                if (!tx_full) begin
                    tx_wr      = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Keep the pop strobe quiet while reset is held so no byte is lost
    always_comb begin
        rx_rd      = rx_pop && !reset;
        imem_addr  = ptr_reg;
        imem_wdata = word_reg;
        dbg_addr   = dump_idx_reg;
    end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Directed bench for uart_debug_ctrl with behavioural RX/TX FIFO models,
// a registered debug read port and an imem write log.
module tb_uart_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_rd;
    logic        tx_full = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        cpu_en;
    logic        cpu_halted = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_rdata = 32'd0;

    int tests = 0;
    int fails = 0;

    // RX FIFO model
    logic [7:0] rx_mem [0:255];
    int rx_wp = 0;
    int rx_rp = 0;
    int rx_viol = 0;
    assign rx_empty = (rx_rp == rx_wp);
    assign rx_data  = rx_mem[rx_rp[7:0]];

    // Logs
    logic [7:0]  tx_log [0:1023];
    int          tx_n = 0;
    int          tx_viol = 0;
    logic [7:0]  im_addr_log [0:63];
    logic [31:0] im_data_log [0:63];
    int          im_n = 0;
    int          cpu_en_n = 0;

    uart_debug_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rx_rd      (rx_rd),
        .tx_full    (tx_full),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data),
        .cpu_en     (cpu_en),
        .cpu_halted (cpu_halted),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    // FIFO pop and registered debug read port
    always @(posedge clk) begin
        if (rx_rd) begin
            if (rx_empty) rx_viol <= rx_viol + 1;
            else          rx_rp   <= rx_rp + 1;
        end
        dbg_rdata <= 32'hA0B0C0D0 + {27'd0, dbg_addr};
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (tx_wr) begin
            if (tx_full) tx_viol <= tx_viol + 1;
            tx_log[tx_n] <= tx_data;
            tx_n <= tx_n + 1;
        end
        if (imem_we) begin
            im_addr_log[im_n] <= imem_addr;
            im_data_log[im_n] <= imem_wdata;
            im_n <= im_n + 1;
        end
        if (cpu_en) cpu_en_n <= cpu_en_n + 1;
    end

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wp[7:0]] = b;
        rx_wp = rx_wp + 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (tx_n < target && k < budget) begin
            cycles(1);
            k++;
        end
        tests++;
        if (tx_n < target) begin
            fails++;
            $display("FAIL %s timeout: tx count %0d, required %0d", name, tx_n, target);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({rx_rd, tx_wr, tx_data, cpu_en, imem_we, imem_addr, imem_wdata, dbg_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rx_rd=%b tx_wr=%b tx_data=%h cpu_en=%b imem_we=%b addr=%h wdata=%h dbg=%h, required all 0",
                     rx_rd, tx_wr, tx_data, cpu_en, imem_we, imem_addr, imem_wdata, dbg_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cycles(2);
        $display("[TB] reset checked");
    endtask

    task automatic test_load_one();
        int t0, i0;
        t0 = tx_n; i0 = im_n;
        push_rx(8'h4C); push_rx(8'h01);
        push_rx(8'h13); push_rx(8'h00); push_rx(8'h00); push_rx(8'h00);
        wait_tx(t0 + 1, 100, "load1_ack");
        cycles(2);
        tests++;
        if (im_n - i0 !== 1) begin
            fails++; $display("FAIL load1_writes: got %0d, required 1", im_n - i0);
        end
        tests++;
        if (im_addr_log[i0] !== 8'h00 || im_data_log[i0] !== 32'h00000013) begin
            fails++; $display("FAIL load1_word: addr %h data %h, required 00 00000013", im_addr_log[i0], im_data_log[i0]);
        end
        tests++;
        if (tx_log[t0] !== 8'h4B) begin
            fails++; $display("FAIL load1_ackbyte: got %h, required 4b", tx_log[t0]);
        end
        $display("[TB] load 1 word: addr %h data %h ack %h", im_addr_log[i0], im_data_log[i0], tx_log[t0]);
    endtask

    task automatic test_load_backpressure();
        int t0, i0, k;
        t0 = tx_n; i0 = im_n;
        tx_full = 1'b1;
        push_rx(8'h4C); push_rx(8'h02);
        push_rx(8'h44); push_rx(8'h33); push_rx(8'h22); push_rx(8'h11);
        push_rx(8'hEF); push_rx(8'hBE); push_rx(8'hAD); push_rx(8'hDE);
        k = 0;
        while (im_n < i0 + 2 && k < 100) begin cycles(1); k++; end
        cycles(5);
        tests++;
        if (im_n - i0 !== 2 || tx_n !== t0) begin
            fails++; $display("FAIL load2_stall: writes %0d tx %0d, required 2 and 0", im_n - i0, tx_n - t0);
        end
        tx_full = 1'b0;
        wait_tx(t0 + 1, 20, "load2_ack");
        cycles(5);
        tests++;
        if (tx_n - t0 !== 1 || tx_log[t0] !== 8'h4B) begin
            fails++; $display("FAIL load2_ack_once: count %0d byte %h, required 1 and 4b", tx_n - t0, tx_log[t0]);
        end
        tests++;
        if (im_addr_log[i0] !== 8'h00 || im_data_log[i0] !== 32'h11223344 ||
            im_addr_log[i0+1] !== 8'h01 || im_data_log[i0+1] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL load2_words: %h:%h %h:%h, required 00:11223344 01:deadbeef",
                              im_addr_log[i0], im_data_log[i0], im_addr_log[i0+1], im_data_log[i0+1]);
        end
        $display("[TB] load 2 words under back-pressure: %h %h", im_data_log[i0], im_data_log[i0+1]);
    endtask

    task automatic test_run();
        int t0, c0, k;
        t0 = tx_n; c0 = cpu_en_n;
        push_rx(8'h52);
        cycles(2);
        push_rx(8'h58);  // must stay queued while the core runs
        k = 0;
        while (cpu_en_n - c0 < 20 && k < 100) begin cycles(1); k++; end
        tests++;
        if (rx_wp - rx_rp !== 1) begin
            fails++; $display("FAIL run_rx_queued: pending %0d, required 1", rx_wp - rx_rp);
        end
        cpu_halted = 1'b1;
        @(negedge clk);
        tests++;
        if (cpu_en !== 1'b0) begin
            fails++; $display("FAIL run_halt_drop: cpu_en %b, required 0", cpu_en);
        end
        wait_tx(t0 + 2, 50, "run_ack");
        cpu_halted = 1'b0;
        tests++;
        if (cpu_en_n - c0 !== 20) begin
            fails++; $display("FAIL run_en_cycles: got %0d, required 20", cpu_en_n - c0);
        end
        tests++;
        if (tx_log[t0] !== 8'h4B || tx_log[t0+1] !== 8'h3F) begin
            fails++; $display("FAIL run_replies: got %h %h, required 4b 3f", tx_log[t0], tx_log[t0+1]);
        end
        $display("[TB] run: cpu_en cycles %0d, replies %h %h", cpu_en_n - c0, tx_log[t0], tx_log[t0+1]);
    endtask

    task automatic test_step_and_error();
        int t0, c0, r0;
        t0 = tx_n; c0 = cpu_en_n; r0 = rx_rp;
        push_rx(8'h53);
        wait_tx(t0 + 1, 20, "step_ack");
        tests++;
        if (cpu_en_n - c0 !== 1 || tx_log[t0] !== 8'h4B) begin
            fails++; $display("FAIL step: en cycles %0d reply %h, required 1 4b", cpu_en_n - c0, tx_log[t0]);
        end
        push_rx(8'h58);
        wait_tx(t0 + 2, 20, "err_reply");
        cycles(2);
        tests++;
        if (tx_log[t0+1] !== 8'h3F) begin
            fails++; $display("FAIL unknown_cmd: got %h, required 3f", tx_log[t0+1]);
        end
        tests++;
        if (rx_rp - r0 !== 2 || rx_rp !== rx_wp) begin
            fails++; $display("FAIL step_pops: got %0d, required 2", rx_rp - r0);
        end
        $display("[TB] step reply %h, unknown reply %h", tx_log[t0], tx_log[t0+1]);
    endtask

    task automatic test_dump();
        int t0, k, bad, first_bad;
        logic [31:0] w;
        logic [7:0]  exp_b;
        t0 = tx_n;
        push_rx(8'h44);
        k = 0;
        while (tx_n < t0 + 128 && k < 2000) begin
            tx_full = (k % 3 == 1);
            cycles(1);
            k++;
        end
        tx_full = 1'b0;
        cycles(10);
        tests++;
        if (tx_n - t0 !== 128) begin
            fails++; $display("FAIL dump_count: got %0d bytes, required 128", tx_n - t0);
        end
        bad = 0; first_bad = -1;
        for (int j = 0; j < 128; j++) begin
            w = 32'hA0B0C0D0 + 32'(j / 4);
            exp_b = w[(j % 4) * 8 +: 8];
            if (tx_log[t0 + j] !== exp_b) begin
                if (first_bad < 0) first_bad = j;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            w = 32'hA0B0C0D0 + 32'(first_bad / 4);
            exp_b = w[(first_bad % 4) * 8 +: 8];
            $display("FAIL dump_bytes: %0d wrong, first at %0d got %h, required %h",
                     bad, first_bad, tx_log[t0 + first_bad], exp_b);
        end
        $display("[TB] dump: %0d bytes, first %h %h %h %h", tx_n - t0,
                 tx_log[t0], tx_log[t0+1], tx_log[t0+2], tx_log[t0+3]);
    endtask

    task automatic test_reset_midload();
        int t0, i0, c0, k;
        i0 = im_n;
        push_rx(8'h4C); push_rx(8'h01); push_rx(8'hAA); push_rx(8'hBB);
        k = 0;
        while (rx_rp != rx_wp && k < 50) begin cycles(1); k++; end
        cycles(1);
        reset = 1'b1;
        #1;
        tests++;
        if ({rx_rd, tx_wr, tx_data, cpu_en, imem_we, imem_addr, imem_wdata, dbg_addr} !== '0) begin
            fails++;
            $display("FAIL midload_reset_outputs: imem_we=%b addr=%h wdata=%h tx_wr=%b cpu_en=%b, required all 0",
                     imem_we, imem_addr, imem_wdata, tx_wr, cpu_en);
        end
        cycles(2);
        reset = 1'b0;
        cycles(2);
        t0 = tx_n; c0 = cpu_en_n;
        push_rx(8'h53);
        wait_tx(t0 + 1, 20, "post_reset_step");
        cycles(2);
        tests++;
        if (im_n !== i0 || cpu_en_n - c0 !== 1 || tx_log[t0] !== 8'h4B) begin
            fails++; $display("FAIL post_reset_step: writes %0d en %0d reply %h, required 0 1 4b",
                              im_n - i0, cpu_en_n - c0, tx_log[t0]);
        end
        $display("[TB] reset mid-load then step: reply %h", tx_log[t0]);
    endtask

    task automatic test_protocol();
        tests++;
        if (rx_viol !== 0 || tx_viol !== 0) begin
            fails++; $display("FAIL handshake: rx pops on empty %0d, tx pushes on full %0d, required 0 0", rx_viol, tx_viol);
        end
    endtask

    initial begin
        test_reset();
        test_load_one();
        test_load_backpressure();
        test_run();
        test_step_and_error();
        test_dump();
        test_reset_midload();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
